// File: rtl/grid_port_arbiter_if.sv
// Requester-side and RAM-side signal bundle for grid_port_arbiter.
// The arbiter connects through the slave modport; the requesters and the
// RAM instance together form the master side.
interface grid_port_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        lock;
    logic [NREQ-1:0]        we;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
    logic                   mem_re;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_din;
    logic [DATA_W-1:0]      mem_dout;

    modport slave (
        input  req, lock, we, addr, wdata, mem_dout,
        output gnt, rvalid, rdata, busy, mem_re, mem_we, mem_addr, mem_din
    );

    modport master (
        output req, lock, we, addr, wdata, mem_dout,
        input  gnt, rvalid, rdata, busy, mem_re, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/grid_port_arbiter.sv
// Round-robin arbiter sharing one single-port placement RAM between NREQ
// requesters. A requester may hold a lock so that a read-check-write
// sequence on the grid is not interleaved with other requesters.
module grid_port_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    grid_port_arbiter_if.slave bus
);
    localparam int             PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W:0] NREQ_P = (PTR_W+1)'(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q;
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  win_q;
    logic [PTR_W-1:0]  owner_q;
    logic              owner_vld_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   rvalid_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;

    logic [NREQ-1:0]   eligible_d;
    logic              found_d;
    logic [PTR_W-1:0]  win_d;
    logic [PTR_W-1:0]  rr_ptr_d;
    logic [PTR_W:0]    scan_d;
    logic [PTR_W:0]    next_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_din_d;
    logic              sel_we_d;
    logic              sel_lock_d;

    // Pick the winner: first eligible requester scanning upward from rr_ptr, restricted to the owner while a lock is held.
    always_comb begin
        eligible_d = bus.req;
        if (owner_vld_q && bus.lock[owner_q]) begin
            eligible_d = bus.req & (NREQ'(1) << owner_q);
        end

        found_d = 1'b0;
        win_d   = '0;
        scan_d  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_d = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan_d >= NREQ_P) begin
                scan_d = scan_d - NREQ_P;
            end
            if (!found_d && eligible_d[scan_d[PTR_W-1:0]]) begin
                found_d = 1'b1;
                win_d   = scan_d[PTR_W-1:0];
            end
        end

        next_d = {1'b0, win_d} + (PTR_W+1)'(1);
        if (next_d >= NREQ_P) begin
            next_d = next_d - NREQ_P;
        end
        rr_ptr_d = next_d[PTR_W-1:0];

        sel_addr_d = '0;
        sel_din_d  = '0;
        sel_we_d   = 1'b0;
        sel_lock_d = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == win_d) begin
                sel_addr_d = bus.addr[i*ADDR_W +: ADDR_W];
                sel_din_d  = bus.wdata[i*DATA_W +: DATA_W];
                sel_we_d   = bus.we[i];
                sel_lock_d = bus.lock[i];
            end
        end
    end

    // Transaction FSM: grant and launch in IDLE, strobe for one cycle in ISSUE, report read data after RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (owner_vld_q && !bus.lock[owner_q]) begin
                        owner_vld_q <= 1'b0;
                    end
                    if (found_d) begin
                        gnt_q       <= NREQ'(1) << win_d;
                        win_q       <= win_d;
                        rr_ptr_q    <= rr_ptr_d;
                        mem_addr_q  <= sel_addr_d;
                        mem_din_q   <= sel_din_d;
                        mem_we_q    <= sel_we_d;
                        mem_re_q    <= ~sel_we_d;
                        owner_q     <= win_d;
                        owner_vld_q <= sel_lock_d;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_re_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= mem_re_q ? RESP : IDLE;
                end
                RESP: begin
                    rvalid_q <= NREQ'(1) << win_q;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = bus.mem_dout;
    assign bus.busy     = (state_q != IDLE);
    assign bus.mem_re   = mem_re_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
endmodule

// File: tb/tb_grid_port_arbiter.sv
// Self-checking bench for grid_port_arbiter: directed scenarios for reset,
// latency, locking and withdrawal, then randomized traffic against a
// transaction-level model of the arbitration and memory contents.
module tb_grid_port_arbiter;
    localparam int NREQ   = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic ramClr = 1'b0;

    grid_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    grid_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    logic [31:0] ram [64];
    logic [63:0] written;

    // Single-port RAM stand-in: registered read, unwritten cells read as -1
    always @(posedge clk or posedge ramClr) begin
        if (ramClr) begin
            written      <= '0;
            bus.mem_dout <= '0;
        end else begin
            if (bus.mem_we) begin
                ram[bus.mem_addr[5:0]]     <= bus.mem_din;
                written[bus.mem_addr[5:0]] <= 1'b1;
            end
            if (bus.mem_re) begin
                bus.mem_dout <= written[bus.mem_addr[5:0]] ? ram[bus.mem_addr[5:0]] : 32'hFFFF_FFFF;
            end
        end
    end

    int          errors;
    int          checks;
    logic [31:0] refMem [64];
    int          expPtr;
    int          cyc;
    int          freeAt;
    int          rvCyc;
    int          rvReq;
    logic [31:0] rvData;
    bit          pendReq  [NREQ];
    bit          pendWe   [NREQ];
    logic [31:0] pendAddr [NREQ];
    logic [31:0] pendData [NREQ];
    int          win;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction on an idle arbiter with no competitor
    task automatic applyStimulus(input int r, input bit wr, input int a, input logic [31:0] d, input bit lk);
        logic [NREQ-1:0] oneHot;
        oneHot                      = '0;
        oneHot[r]                   = 1'b1;
        bus.req[r]                  = 1'b1;
        bus.we[r]                   = wr;
        bus.lock[r]                 = lk;
        bus.addr[r*ADDR_W +: ADDR_W] = a;
        bus.wdata[r*DATA_W +: DATA_W] = d;
        tick();
        checkOutput("gnt", bus.gnt, oneHot);
        checkOutput("strobes", {bus.mem_we, bus.mem_re}, {wr, ~wr});
        checkOutput("mem_addr", bus.mem_addr, a);
        checkOutput("busy_issue", bus.busy, 1'b1);
        bus.req[r] = 1'b0;
        expPtr     = (r + 1) % NREQ;
        if (wr) begin
            checkOutput("mem_din", bus.mem_din, d);
            refMem[a] = d;
            tick();
            checkOutput("gnt_drop", bus.gnt, 0);
            checkOutput("busy_after_write", bus.busy, 1'b0);
        end else begin
            tick();
            checkOutput("strobe_drop", {bus.mem_we, bus.mem_re}, 2'b00);
            checkOutput("rvalid_early", bus.rvalid, 0);
            tick();
            checkOutput("rvalid", bus.rvalid, oneHot);
            checkOutput("rdata", bus.rdata, refMem[a]);
        end
    endtask

    task automatic newOp(input int i);
        pendReq[i]  = 1'b1;
        pendWe[i]   = 1'($urandom_range(0, 1));
        pendAddr[i] = $urandom_range(0, 15);
        pendData[i] = $urandom;
    endtask

    // One clock of the transaction-level model: who should be granted and which read completes
    task automatic stepModel(output int w);
        logic [NREQ-1:0] expG;
        logic [NREQ-1:0] expV;
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]                   = pendReq[i];
            bus.we[i]                    = pendWe[i];
            bus.lock[i]                  = 1'b0;
            bus.addr[i*ADDR_W +: ADDR_W]  = pendAddr[i];
            bus.wdata[i*DATA_W +: DATA_W] = pendData[i];
        end
        tick();
        cyc++;
        w = -1;
        if (cyc >= freeAt) begin
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && pendReq[(expPtr + k) % NREQ]) w = (expPtr + k) % NREQ;
            end
        end
        expG = '0;
        if (w >= 0) expG[w] = 1'b1;
        checkOutput("model_gnt", bus.gnt, expG);
        checkOutput("model_we", bus.mem_we, (w >= 0) && pendWe[w]);
        checkOutput("model_re", bus.mem_re, (w >= 0) && !pendWe[w]);
        checkOutput("strobe_excl", bus.mem_re & bus.mem_we, 1'b0);
        expV = '0;
        if (cyc == rvCyc) expV[rvReq] = 1'b1;
        checkOutput("model_rvalid", bus.rvalid, expV);
        if (cyc == rvCyc) checkOutput("model_rdata", bus.rdata, rvData);
        if (w >= 0) begin
            checkOutput("model_addr", bus.mem_addr, pendAddr[w]);
            expPtr = (w + 1) % NREQ;
            if (pendWe[w]) begin
                checkOutput("model_din", bus.mem_din, pendData[w]);
                refMem[pendAddr[w][5:0]] = pendData[w];
                freeAt = cyc + 2;
            end else begin
                rvCyc  = cyc + 2;
                rvReq  = w;
                rvData = refMem[pendAddr[w][5:0]];
                freeAt = cyc + 3;
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        expPtr = 0;
        cyc    = 0;
        freeAt = 0;
        rvCyc  = -1;
        rvReq  = 0;
        rvData = '0;
        for (int i = 0; i < 64; i++) refMem[i] = 32'hFFFF_FFFF;
        for (int i = 0; i < NREQ; i++) begin
            pendReq[i]  = 1'b0;
            pendWe[i]   = 1'b0;
            pendAddr[i] = '0;
            pendData[i] = '0;
        end
        bus.req   = '0;
        bus.lock  = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        rst       = 1'b1;
        #1 ramClr = 1'b1;
        #1 ramClr = 1'b0;

        $display("[TB] reset state");
        tick();
        checkOutput("rst_gnt", bus.gnt, 0);
        checkOutput("rst_rvalid", bus.rvalid, 0);
        checkOutput("rst_mem_re", bus.mem_re, 0);
        checkOutput("rst_mem_we", bus.mem_we, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_mem_addr", bus.mem_addr, 0);
        checkOutput("rst_mem_din", bus.mem_din, 0);
        rst = 1'b0;
        tick();

        $display("[TB] single read of unwritten cell");
        applyStimulus(0, 1'b0, 5, 32'h0, 1'b0);

        $display("[TB] reset during RESP");
        bus.req[0]              = 1'b1;
        bus.we[0]               = 1'b0;
        bus.addr[0 +: ADDR_W]   = 5;
        tick();
        checkOutput("pre_rst_gnt", bus.gnt, 2'b01);
        bus.req[0] = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checkOutput("midrst_rvalid", bus.rvalid, 0);
        checkOutput("midrst_strobes", {bus.mem_we, bus.mem_re}, 2'b00);
        checkOutput("midrst_busy", bus.busy, 0);
        tick();
        checkOutput("midrst_rvalid_held", bus.rvalid, 0);
        rst    = 1'b0;
        expPtr = 0;
        bus.req                  = 2'b11;
        bus.we                   = 2'b11;
        bus.addr                 = {32'd31, 32'd30};
        bus.wdata                = {32'h2222, 32'h1111};
        tick();
        checkOutput("rr_after_reset", bus.gnt, 2'b01);
        refMem[30] = 32'h1111;
        expPtr     = 1;
        bus.req    = '0;
        tick();
        checkOutput("busy_idle", bus.busy, 0);
        checkOutput("withdrawn_no_gnt", bus.gnt, 0);

        $display("[TB] write then read from the other requester");
        applyStimulus(1, 1'b1, 2, 32'd7, 1'b0);
        applyStimulus(0, 1'b0, 2, 32'h0, 1'b0);

        $display("[TB] locked read-check-write");
        bus.req[0] = 1'b1; bus.we[0] = 1'b0; bus.lock[0] = 1'b1;
        bus.addr[0 +: ADDR_W] = 9;
        tick();
        checkOutput("lock_gnt0", bus.gnt, 2'b01);
        bus.req[0] = 1'b0;
        bus.req[1] = 1'b1; bus.we[1] = 1'b0; bus.lock[1] = 1'b0;
        bus.addr[ADDR_W +: ADDR_W] = 9;
        tick();
        checkOutput("lock_issue_gnt", bus.gnt, 0);
        tick();
        checkOutput("lock_rvalid", bus.rvalid, 2'b01);
        checkOutput("lock_rdata", bus.rdata, 32'hFFFF_FFFF);
        bus.req[0] = 1'b1; bus.we[0] = 1'b1;
        bus.wdata[0 +: DATA_W] = 32'd3;
        tick();
        checkOutput("lock_owner_wins", bus.gnt, 2'b01);
        checkOutput("lock_write_addr", bus.mem_addr, 9);
        refMem[9]  = 32'd3;
        bus.req[0] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput("lock_stall", bus.gnt, 0);
        end
        bus.lock[0] = 1'b0;
        tick();
        checkOutput("lock_release_gnt1", bus.gnt, 2'b10);
        bus.req[1] = 1'b0;
        expPtr     = 0;
        tick();
        tick();
        checkOutput("lock_rvalid1", bus.rvalid, 2'b10);
        checkOutput("lock_rdata1", bus.rdata, 32'd3);

        $display("[TB] withdrawn request while busy");
        bus.req[0] = 1'b1; bus.we[0] = 1'b0;
        bus.addr[0 +: ADDR_W] = 4;
        tick();
        checkOutput("wd_gnt0", bus.gnt, 2'b01);
        expPtr     = 1;
        bus.req[0] = 1'b0;
        bus.req[1] = 1'b1; bus.we[1] = 1'b1;
        bus.addr[ADDR_W +: ADDR_W]   = 1;
        bus.wdata[DATA_W +: DATA_W]  = 32'hAA;
        tick();
        bus.req[1] = 1'b0;
        checkOutput("wd_no_gnt_a", bus.gnt, 0);
        tick();
        checkOutput("wd_no_gnt_b", bus.gnt, 0);
        checkOutput("wd_rvalid", bus.rvalid, 2'b01);
        checkOutput("wd_rdata", bus.rdata, 32'hFFFF_FFFF);
        for (int n = 0; n < 2; n++) begin
            tick();
            checkOutput("wd_no_gnt_c", bus.gnt, 0);
            checkOutput("wd_no_write", bus.mem_we, 0);
        end
        applyStimulus(1, 1'b0, 1, 32'h0, 1'b0);

        $display("[TB] both requesters streaming writes");
        cyc    = 0;
        freeAt = 0;
        rvCyc  = -1;
        pendReq[0] = 1'b1; pendWe[0] = 1'b1; pendAddr[0] = 20; pendData[0] = 32'hA0;
        pendReq[1] = 1'b1; pendWe[1] = 1'b1; pendAddr[1] = 21; pendData[1] = 32'hB1;
        for (int n = 0; n < 8; n++) stepModel(win);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            stepModel(win);
            if (win >= 0) begin
                if ($urandom_range(0, 3) == 0) newOp(win);
                else pendReq[win] = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!pendReq[i] && $urandom_range(0, 1) == 1) newOp(i);
            end
        end
        for (int i = 0; i < NREQ; i++) pendReq[i] = 1'b0;
        for (int n = 0; n < 4; n++) stepModel(win);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
